// File: rtl/inv_sub_bytes_serial_if.sv
// Handshake bundle for the serial InvSubBytes stage: input word channel and result channel.
interface inv_sub_bytes_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_word;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_word;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word
    );
endinterface

// File: rtl/inv_sub_bytes_serial.sv
// Serial AES InvSubBytes: BPC shared inverse S-boxes walk the word byte 0 first, latency 16/BPC cycles.
// Result is held in DONE until out_ready; in_ready is high only in IDLE.
module inv_sub_bytes_serial #(
    parameter int BPC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_sub_bytes_serial_if.slave bus
);
    localparam int N  = 16 / BPC;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    state_t       r_state;
    state_t       w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [0:127] r_buf;
    logic [0:127] w_buf_sub;
    logic         w_last;

    assign w_last = (r_ptr == PW'(N - 1));

    // Only the current group of BPC bytes goes through the shared S-boxes.
    always_comb begin
        w_buf_sub = r_buf;
        for (int b = 0; b < BPC; b++) begin
            w_buf_sub[(int'(r_ptr) * BPC + b) * 8 +: 8] =
                INV_SBOX[r_buf[(int'(r_ptr) * BPC + b) * 8 +: 8]];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = BUSY;
            BUSY:    if (w_last)       w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_ptr <= '0;
        end else if (r_state == IDLE) begin
            if (bus.in_valid) begin
                r_buf <= bus.in_word;
                r_ptr <= '0;
            end
        end else if (r_state == BUSY) begin
            r_buf <= w_buf_sub;
            r_ptr <= w_last ? '0 : r_ptr + 1'b1;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_word  = r_buf;
endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Directed scoreboard bench for inv_sub_bytes_serial at BPC = 4, 1 and 16.
module tb_inv_sub_bytes_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         in_valid_a  [3];
    logic [0:127] in_word_a   [3];
    logic         out_ready_a [3];
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic [0:127] out_word_a  [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int P = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
            inv_sub_bytes_serial_if bus ();
            assign bus.in_valid   = in_valid_a[g];
            assign bus.in_word    = in_word_a[g];
            assign bus.out_ready  = out_ready_a[g];
            assign in_ready_a[g]  = bus.in_ready;
            assign out_valid_a[g] = bus.out_valid;
            assign out_word_a[g]  = bus.out_word;
            inv_sub_bytes_serial #(.BPC(P)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus.slave)
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int sel;
    int nn;
    logic [0:127] exp_q [$];
    logic [7:0]   isb [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (sel=%0d): observed %h expected %h", tag, sel, obs, exp);
        end
    endtask

    // Reference inverse S-box derived from the forward S-box (GF(2^8) inverse + affine map).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (a != 8'h00 && gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] w);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = isb[w[8*k +: 8]];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        check("reset_in_ready", 128'(in_ready_a[sel]), 128'd1);
        check("reset_out_valid", 128'(out_valid_a[sel]), 128'd0);
        check("reset_out_word", out_word_a[sel], 128'd0);
    endtask

    // Returns at the negedge of the accept cycle with acc = cycle number of the accept edge.
    task automatic send(input logic [0:127] w, input logic [0:127] expw, output int acc);
        logic got;
        got = 1'b0;
        acc = -1;
        @(negedge clk);
        in_valid_a[sel] = 1'b1;
        in_word_a[sel]  = w;
        for (int i = 0; i < 50 && !got; i++) begin
            if (in_ready_a[sel]) begin
                @(posedge clk);
                #1;
                acc = cyc;
                got = 1'b1;
                exp_q.push_back(expw);
            end
            @(negedge clk);
        end
        in_valid_a[sel] = 1'b0;
        check("accept_seen", 128'(got), 128'd1);
    endtask

    task automatic recv(input int acc, input int stall, input int exp_lat);
        logic [0:127] hold;
        logic [0:127] expw;
        int n = 0;
        while (n < 100 && !out_valid_a[sel]) begin
            if (in_ready_a[sel]) begin
                check("in_ready_busy", 128'(in_ready_a[sel]), 128'd0);
            end
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 128'(out_valid_a[sel]), 128'd1);
        check("latency", 128'(cyc - acc), 128'(exp_lat));
        hold = out_word_a[sel];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 128'(out_valid_a[sel]), 128'd1);
            check("stall_stable", out_word_a[sel], hold);
            check("stall_in_ready", 128'(in_ready_a[sel]), 128'd0);
        end
        expw = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        check("out_word", out_word_a[sel], expw);
        out_ready_a[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_a[sel] = 1'b0;
        check("release_out_valid", 128'(out_valid_a[sel]), 128'd0);
        check("release_in_ready", 128'(in_ready_a[sel]), 128'd1);
    endtask

    task automatic back_to_back();
        int na = 0;
        int nout = 0;
        int accs [2];
        logic [0:127] expw;
        @(negedge clk);
        in_valid_a[sel]  = 1'b1;
        in_word_a[sel]   = {16{8'h00}};
        out_ready_a[sel] = 1'b1;
        for (int i = 0; i < 80 && nout < 2; i++) begin
            if (in_valid_a[sel] && in_ready_a[sel]) begin
                exp_q.push_back(na == 0 ? {16{8'h52}} : {16{8'h7d}});
                accs[na] = cyc + 1;
                na++;
            end
            if (out_valid_a[sel] && out_ready_a[sel]) begin
                expw = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                check("b2b_out_word", out_word_a[sel], expw);
                nout++;
            end
            @(negedge clk);
            if (na == 1) in_word_a[sel] = {16{8'hff}};
            if (na == 2) in_valid_a[sel] = 1'b0;
        end
        in_valid_a[sel]  = 1'b0;
        out_ready_a[sel] = 1'b0;
        check("b2b_outputs", 128'(nout), 128'd2);
        check("b2b_accepts", 128'(na), 128'd2);
        if (na == 2) check("b2b_spacing", 128'(accs[1] - accs[0]), 128'(nn + 2));
    endtask

    task automatic mid_reset();
        int acc;
        logic [0:127] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        send(w, model(w), acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 128'(out_valid_a[sel]), 128'd0);
        check("midrst_buf_clear", out_word_a[sel], 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_out_valid", 128'(out_valid_a[sel]), 128'd0);
        end
        w = {$urandom, $urandom, $urandom, $urandom};
        send(w, model(w), acc);
        recv(acc, 0, nn);
    endtask

    initial begin
        int acc;
        logic [0:127] w;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_word_a[i]   = '0;
            out_ready_a[i] = 1'b0;
        end
        for (int x = 0; x < 256; x++) isb[sbox(8'(x))] = 8'(x);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            nn  = (s == 0) ? 4 : ((s == 1) ? 16 : 1);
            do_reset();

            // out_ready with nothing pending must not produce anything.
            out_ready_a[sel] = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("idle_out_valid", 128'(out_valid_a[sel]), 128'd0);
            end
            out_ready_a[sel] = 1'b0;

            send({16{8'h63}}, 128'd0, acc);
            recv(acc, 0, nn);

            send(128'h00_01_16_63_7c_ff_00_01_16_63_7c_ff_00_01_16_63,
                 128'h52_09_ff_00_01_7d_52_09_ff_00_01_7d_52_09_ff_00, acc);
            recv(acc, 0, nn);

            w = {$urandom, $urandom, $urandom, $urandom};
            send(w, model(w), acc);
            recv(acc, 10, nn);

            w = 128'h00_11_22_33_44_55_66_77_88_99_aa_bb_cc_dd_ee_ff;
            send(w, model(w), acc);
            recv(acc, 0, nn);

            back_to_back();
            mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
